// File: rtl/mips_cpu_div_unit_if.sv
// Start/done handshake and operand/result bus between the CPU datapath and the divider.
interface mips_cpu_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             valid_out;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output valid_in, is_signed, dividend, divisor,
    input  busy, valid_out, quotient, remainder, div_by_zero
  );

  modport slave (
    input  valid_in, is_signed, dividend, divisor,
    output busy, valid_out, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mips_cpu_div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Fixed 33-cycle latency from start to valid results, independent of operands.
//
// state | meaning
// IDLE  | waiting for the first start request
// CALC  | one quotient bit per cycle, 32 cycles
// FIX   | apply signs to magnitude results, publish outputs
// DONE  | results held stable; a new start is accepted here
module mips_cpu_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               reset,
  mips_cpu_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [CNT_W-1:0] r_count;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_start;
  logic [WIDTH-1:0] w_abs_dividend;
  logic [WIDTH-1:0] w_abs_divisor;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_p_next;

  assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.valid_in;

  assign w_abs_dividend = (bus.is_signed && bus.dividend[WIDTH-1]) ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_abs_divisor  = (bus.is_signed && bus.divisor[WIDTH-1])  ? (~bus.divisor + 1'b1)  : bus.divisor;

  // The full partial remainder is kept in the shift: with a divisor near 2^WIDTH-1
  // the remainder can have its top bit set, so the trial value needs WIDTH+1 bits.
  assign w_t      = {r_p, r_a[WIDTH-1]};
  assign w_ge     = (w_t >= {1'b0, r_b});
  assign w_diff   = w_t[WIDTH-1:0] - r_b;
  assign w_p_next = w_ge ? w_diff : w_t[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.valid_in) w_next = S_CALC;
      S_CALC:  if (r_count == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (bus.valid_in) w_next = S_CALC;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a           <= '0;
      r_b           <= '0;
      r_p           <= '0;
      r_count       <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_start) begin
      r_sign_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_sign_r <= bus.is_signed & bus.dividend[WIDTH-1];
      r_a      <= w_abs_dividend;
      r_b      <= w_abs_divisor;
      r_dz     <= (bus.divisor == '0);
      r_p      <= '0;
      r_count  <= CNT_W'(WIDTH - 1);
    end else if (r_state == S_CALC) begin
      r_p     <= w_p_next;
      r_a     <= {r_a[WIDTH-2:0], w_ge};
      r_count <= r_count - 1'b1;
    end else if (r_state == S_FIX) begin
      r_quotient    <= r_sign_q ? (~r_a + 1'b1) : r_a;
      r_remainder   <= r_sign_r ? (~r_p + 1'b1) : r_p;
      r_div_by_zero <= r_dz;
    end
  end

  assign bus.busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.valid_out   = (r_state == S_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_mips_cpu_div_unit.sv
// Directed bench for the MIPS divider: stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on each rising valid_out.
module tb_mips_cpu_div_unit;

  typedef struct {
    int unsigned start;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        reset;
  int unsigned cyc;
  int          checks;
  int          errors;
  exp_t        sb_q[$];
  logic        prev_vo;

  mips_cpu_div_unit_if #(.WIDTH(32)) bus ();

  mips_cpu_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each newly presented result against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.valid_out && !prev_vo) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_out=1 expected no result pending");
        end else begin
          e = sb_q.pop_front();
          chk("latency", cyc - e.start, 32'd33);
          chk("quotient", bus.quotient, e.q);
          chk("remainder", bus.remainder, e.r);
          chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
          chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        end
      end else if (sb_q.size() > 0) begin
        if (cyc == sb_q[0].start + 32) begin
          chk("busy_e32", {31'd0, bus.busy}, 32'd1);
          chk("valid_e32", {31'd0, bus.valid_out}, 32'd0);
        end
        if (cyc > sb_q[0].start + 40) begin
          checks++;
          errors++;
          $display("FAIL timeout: got no valid_out after %0d cycles expected 33", cyc - sb_q[0].start);
          void'(sb_q.pop_front());
        end
      end
    end
    prev_vo = bus.valid_out;
  end

  task automatic start(input logic s, input logic [31:0] dd, input logic [31:0] dv,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz, input bit push);
    exp_t e;
    @(negedge clk);
    bus.valid_in  = 1'b1;
    bus.is_signed = s;
    bus.dividend  = dd;
    bus.divisor   = dv;
    if (push) begin
      e.start = cyc + 1;
      e.q = eq; e.r = er; e.dz = edz;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.is_signed = 1'($urandom);
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.valid_out) break;
    end
    @(negedge clk);
  endtask

  task automatic check_hold(input string name, input logic [31:0] q, input logic [31:0] r);
    repeat (3) @(negedge clk);
    chk({name, "_hold_valid"}, {31'd0, bus.valid_out}, 32'd1);
    chk({name, "_hold_q"}, bus.quotient, q);
    chk({name, "_hold_r"}, bus.remainder, r);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    chk({name, "_q"}, bus.quotient, 32'd0);
    chk({name, "_r"}, bus.remainder, 32'd0);
    chk({name, "_dz"}, {31'd0, bus.div_by_zero}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; prev_vo = 1'b0;
    reset = 1'b0;
    bus.valid_in = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;

    // Reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      bus.valid_in  = 1'($urandom);
      bus.is_signed = 1'($urandom);
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
    end
    @(negedge clk);
    check_zero("reset");
    bus.valid_in = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("idle");

    // DIVU 100 / 7
    start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    wait_done();
    check_hold("divu", 32'd14, 32'd2);

    // DIV -7 / 2 and 7 / -2
    start(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done();
    start(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
    wait_done();
    // DIV -100 / -7
    start(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b1);
    wait_done();

    // Edge operands
    start(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    wait_done();
    start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    wait_done();
    start(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
    wait_done();

    // Start pulse while busy is ignored
    start(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    chk("busy_mid", {31'd0, bus.busy}, 32'd1);
    start(1'b0, 32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_done();
    check_hold("ignore", 32'd2, 32'd1);

    // Back-to-back restart from DONE
    start(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    chk("b2b_valid_drop", {31'd0, bus.valid_out}, 32'd0);
    chk("b2b_prev_q", bus.quotient, 32'd2);
    chk("b2b_prev_r", bus.remainder, 32'd1);
    wait_done();

    // Asynchronous reset mid-calculation
    start(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    start(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b1);
    wait_done();

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
